// File: rtl/rv32_mc_ctrl_fsm.sv
// rv32_mc_ctrl_fsm: multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb)
// driving datapath strobes and memory handshakes from the major opcode.
module rv32_mc_ctrl_fsm #(
    parameter bit RESET_PC_WE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    input  logic       imem_ack_i,
    input  logic       dmem_ack_i,
    output logic       imem_req_o,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       rf_we_o,
    output logic [1:0] wb_sel_o,
    output logic       alu_a_sel_o,
    output logic       alu_b_sel_o,
    output logic       instret_o,
    output logic       halt_o,
    output logic       illegal_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       halt_q, halt_d, illegal_q, illegal_d, first_q;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic       alu_a_sel, alu_b_sel, instret, legal;
    logic [1:0] pc_sel, wb_sel;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        instret   = 1'b0;
        legal     = opcode_i inside {OP_IMM, OP, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI, SYSTEM};
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack_i;
                state_d  = imem_ack_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                op_d      = opcode_i;
                halt_d    = !legal || opcode_i == SYSTEM;
                illegal_d = !legal;
                state_d   = halt_d ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_a_sel = op_q == AUIPC;
                alu_b_sel = op_q inside {OP_IMM, LOAD, STORE, JALR, AUIPC};
                if (op_q == LOAD || op_q == STORE) begin
                    state_d = S_MEM;
                end else if (op_q == BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken_i ? 2'd1 : 2'd0;
                    instret = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = op_q == STORE;
                alu_a_sel = 1'b0;
                alu_b_sel = 1'b1;
                pc_we     = dmem_ack_i && op_q == STORE;
                instret   = pc_we;
                state_d   = !dmem_ack_i ? S_MEM : (op_q == STORE ? S_FETCH : S_WB);
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                wb_sel  = op_q == LOAD ? 2'd1 : (op_q == JAL || op_q == JALR) ? 2'd2 : op_q == LUI ? 2'd3 : 2'd0;
                pc_sel  = op_q == JAL ? 2'd1 : op_q == JALR ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Optional PC load to the reset vector on the first cycle out of reset
        if (RESET_PC_WE && first_q) pc_we = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
            first_q   <= 1'b0;
        end
    end

    // Every output is forced low while reset is held, independent of state
    assign imem_req_o  = rst_n & imem_req;
    assign dmem_req_o  = rst_n & dmem_req;
    assign dmem_we_o   = rst_n & dmem_we;
    assign ir_we_o     = rst_n & ir_we;
    assign pc_we_o     = rst_n & pc_we;
    assign pc_sel_o    = rst_n ? pc_sel : 2'd0;
    assign rf_we_o     = rst_n & rf_we;
    assign wb_sel_o    = rst_n ? wb_sel : 2'd0;
    assign alu_a_sel_o = rst_n & alu_a_sel;
    assign alu_b_sel_o = rst_n & alu_b_sel;
    assign instret_o   = rst_n & instret;
    assign halt_o      = rst_n & halt_q;
    assign illegal_o   = rst_n & illegal_q;
    assign state_o     = rst_n ? state_q : 3'd0;
endmodule

// File: doc/rv32_mc_ctrl_fsm.md
# rv32_mc_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes and mux selects from the 7-bit major opcode. It stalls on instruction-memory and data-memory handshakes. It stops in a halt state on SYSTEM or on an unrecognised opcode. It sits between the IR/PC/register-file/ALU datapath and the two memory ports.

## Interface
- RESET_PC_WE, 0: when 1, pulse pc_we_o with pc_sel_o=0 for one cycle on the first post-reset cycle (default off)
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode_i  in  7  IR[6:0]; sampled in DECODE
- branch_taken_i  in  1  comparator result; valid in EXEC
- imem_ack_i  in  1  instruction word valid this cycle
- dmem_ack_i  in  1  data access complete this cycle
- imem_req_o  out  1  instruction fetch request
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = store, 0 = load; valid while dmem_req_o=1
- ir_we_o  out  1  load IR
- pc_we_o  out  1  update PC
- pc_sel_o  out  2  0 pc+4, 1 pc+imm, 2 ALU result with bit0 cleared
- rf_we_o  out  1  register-file write
- wb_sel_o  out  2  0 ALU, 1 load data, 2 pc+4, 3 imm (LUI)
- alu_a_sel_o  out  1  0 rs1, 1 pc
- alu_b_sel_o  out  1  0 rs2, 1 imm
- instret_o  out  1  one-cycle pulse per retired instruction
- halt_o  out  1  sticky; core stopped
- illegal_o  out  1  sticky; halt was caused by an unknown opcode
- state_o  out  3  current state encoding (debug)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 are unreachable and recover to FETCH.
- Legal opcodes: OP_IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111, SYSTEM 1110011.
- FETCH: imem_req_o=1. Held until imem_ack_i. In the ack cycle, ir_we_o=1 and the next state is DECODE.
- DECODE: opcode_i is latched into internal op_q.
  - SYSTEM goes to HALT with illegal_o=0.
  - Any other unlisted opcode goes to HALT with illegal_o=1.
  - Everything else goes to EXEC.
- EXEC, ALU selects from op_q:
  - alu_a_sel_o=1 only for AUIPC.
  - alu_b_sel_o=1 for OP_IMM, LOAD, STORE, JALR, AUIPC.
  - alu_b_sel_o=0 otherwise.
- EXEC, next state:
  - LOAD or STORE goes to MEM.
  - BRANCH retires here: pc_we_o=1, pc_sel_o = branch_taken_i ? 1 : 0, instret_o=1, then FETCH.
  - All other opcodes go to WB.
- MEM: dmem_req_o=1 and dmem_we_o=(op_q==STORE), held until dmem_ack_i. ALU selects are held from EXEC.
  - On ack with LOAD, go to WB.
  - On ack with STORE, pc_we_o=1, pc_sel_o=0, instret_o=1, then FETCH.
- WB: rf_we_o=1, pc_we_o=1, instret_o=1, then FETCH.
  - wb_sel_o: LOAD→1, JAL/JALR→2, LUI→3, else 0.
  - pc_sel_o: JAL→1, JALR→2, else 0.
- HALT: every strobe and request is 0. Remains in HALT until rst_n=0.
- Strobes are decoded combinationally from the registered state, op_q and the ack/taken inputs.
- No strobe other than those listed above is asserted in any state.

## Timing
- Reset: while rst_n=0 at a clock edge, the state goes to FETCH and op_q, halt_o and illegal_o go to 0.
- While rst_n is low, all outputs are 0. imem_req_o rises in the first cycle after rst_n is sampled high.
- Latency with zero-wait acks (acks in the same cycle as the request):
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each cycle an ack is withheld adds one cycle.
- An ack arriving while the corresponding request is low is ignored.
- Requests stay asserted every cycle until acked, and drop in the cycle after the ack.
- Reset mid-handshake (FETCH or MEM): the request is 0 while rst_n=0. A later ack for the aborted access is ignored unless the state is FETCH again.
- halt_o and illegal_o rise in the cycle after DECODE and stay high until reset.
- instret_o is high for exactly one cycle per retired instruction and never in HALT.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles → all outputs 0 and state_o=0; release → imem_req_o=1 on the next cycle.
- ADDI, opcode 0010011, all acks immediate → state_o sequence 0,1,2,4; alu_b_sel_o=1 in EXEC; in WB rf_we_o=1, wb_sel_o=0, pc_sel_o=0; one instret_o pulse; next fetch on cycle 5.
- LOAD with dmem_ack_i delayed 2 cycles → dmem_req_o=1 for 3 cycles with dmem_we_o=0; then WB with wb_sel_o=1; total 7 cycles.
- BRANCH with branch_taken_i=1, then a second BRANCH with branch_taken_i=0 → pc_we_o in EXEC with pc_sel_o=1, then 0; rf_we_o never asserted.
- Opcode 1111111 → HALT; illegal_o=1, halt_o=1; imem_req_o stays 0 for 20 cycles. Repeat with SYSTEM → halt_o=1, illegal_o=0.
- STORE stalled in MEM, then rst_n=0 for 1 cycle → dmem_req_o=0 during reset; then FETCH; a stale dmem_ack_i pulse causes no state change.
